fetch_unit: RTL and testbench

Instruction fetch stage directly downstream of the PC register. Each cycle it presents the current PC to instruction memory, tracks outstanding requests, and buffers returned words with their PCs in a DEPTH-entry in-order queue for decode. It drives `pc_hold` back to the PC register whenever a fetch is not accepted. On a redirect it flushes the queue and discards responses still in flight. Memory-side parity errors are tagged so the fault-tolerance logic can act on them.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC to imem, queues responses in order with their PCs for decode.
// Fill-to-valid latency 1 cycle; holds the PC register while the queue has no free slot or imem stalls.
module fetch_unit #(
   parameter int          DEPTH = 2,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        pc_redirect,
   output logic        pc_hold,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        inst_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    head_q, head_d, fill_q, fill_d, tail_q, tail_d, drop_q, drop_d;
   logic [DEPTH-1:0] filled_q, filled_d, fault_q, fault_d;
   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      pc_d   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];

   logic [AW-1:0] head_idx, fill_idx, tail_idx;
   logic [PW-1:0] allocated, unfilled;
   logic [PW:0]   free, drop_sum;
   logic          accept, pop, resp_drop, resp_fill;

   assign head_idx  = head_q[AW-1:0];
   assign fill_idx  = fill_q[AW-1:0];
   assign tail_idx  = tail_q[AW-1:0];
   assign allocated = tail_q - head_q;
   assign unfilled  = tail_q - fill_q;

   // A slot being popped this cycle is immediately reusable by a new request.
   assign pop  = inst_valid && inst_ready;
   assign free = (PW+1)'(DEPTH) - {1'b0, allocated} + {{PW{1'b0}}, pop};

   assign imem_req_valid = !reset && !pc_redirect && (free != '0);
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;
   assign pc_hold        = !reset && !pc_redirect && !accept;

   assign resp_drop = imem_resp_valid && (drop_q != '0);
   assign resp_fill = imem_resp_valid && (drop_q == '0) && (unfilled != '0);

   assign inst_valid = !reset && !pc_redirect && filled_q[head_idx];
   assign inst_data  = data_q[head_idx];
   assign inst_pc    = pc_q[head_idx];
   assign inst_fault = fault_q[head_idx];

   always_comb begin
      head_d   = head_q;
      fill_d   = fill_q;
      tail_d   = tail_q;
      drop_d   = drop_q;
      filled_d = filled_q;
      fault_d  = fault_q;
      pc_d     = pc_q;
      data_d   = data_q;
      drop_sum = '0;
      if (pc_redirect) begin
         head_d   = '0;
         fill_d   = '0;
         tail_d   = '0;
         filled_d = '0;
         // Every unfilled entry is still owed by memory; a response arriving now retires one of them.
         drop_sum = {1'b0, drop_q} + {1'b0, unfilled} - {{PW{1'b0}}, (resp_drop || resp_fill)};
         drop_d   = (drop_sum > (PW+1)'(DEPTH)) ? PW'(DEPTH) : drop_sum[PW-1:0];
      end else begin
         if (pop) begin
            filled_d[head_idx] = 1'b0;
            head_d             = head_q + PW'(1);
         end
         if (accept) begin
            pc_d[tail_idx]     = pc;
            filled_d[tail_idx] = 1'b0;
            tail_d             = tail_q + PW'(1);
         end
         if (resp_drop) begin
            drop_d = drop_q - PW'(1);
         end else if (resp_fill) begin
            data_d[fill_idx]   = imem_resp_err ? NOP : imem_resp_data;
            fault_d[fill_idx]  = imem_resp_err;
            filled_d[fill_idx] = 1'b1;
            fill_d             = fill_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q   <= '0;
         fill_q   <= '0;
         tail_q   <= '0;
         drop_q   <= '0;
         filled_q <= '0;
         fault_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q   <= head_d;
         fill_q   <= fill_d;
         tail_q   <= tail_d;
         drop_q   <= drop_d;
         filled_q <= filled_d;
         fault_q  <= fault_d;
         pc_q     <= pc_d;
         data_q   <= data_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and latency-programmable memory models, scoreboard on decode side.
module tb_fetch_unit;
   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        pc_redirect;
   logic        pc_hold;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        inst_ready;

   fetch_unit dut (
      .clk(clk), .reset(reset), .pc(pc), .pc_redirect(pc_redirect), .pc_hold(pc_hold),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_fault(inst_fault),
      .inst_ready(inst_ready)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        fault;
   } exp_t;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } pend_t;

   exp_t        exp_q[$];
   pend_t       pend_q[$];
   int          checks = 0;
   int          errors = 0;
   int          lat = 1;
   int          mcyc = 0;
   int          last_due = 0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic [31:0] redir_target = 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Memory: accepts at negedge, answers in order L cycles later.
   initial begin
      pend_t p;
      exp_t  e;
      int    due;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_err   = 1'b0;
      forever begin
         @(negedge clk);
         mcyc++;
         if (imem_req_valid && imem_req_ready) begin
            due = mcyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            p.due  = due;
            p.addr = imem_req_addr;
            pend_q.push_back(p);
            e.pc    = imem_req_addr;
            e.fault = (imem_req_addr == err_addr);
            e.data  = e.fault ? 32'h0000_0013 : mem_word(imem_req_addr);
            exp_q.push_back(e);
         end
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
         imem_resp_err   = 1'b0;
         if (pend_q.size() > 0 && pend_q[0].due <= mcyc) begin
            p = pend_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_err   = (p.addr == err_addr);
            imem_resp_data  = imem_resp_err ? 32'hDEAD_BEEF : mem_word(p.addr);
         end
      end
   end

   // Decode-side monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got pc %h expected no instruction", inst_pc);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", inst_pc, e.pc);
               check("sb_data", inst_data, e.data);
               check("sb_fault", {31'h0, inst_fault}, {31'h0, e.fault});
            end
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got no end of stimulus expected finish before 100000");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   task automatic settle();
      #2;
   endtask

   // One cycle: also models the PC register using pc_hold/redirect seen this cycle.
   task automatic step();
      logic h, r, rs;
      @(negedge clk);
      h  = pc_hold;
      r  = pc_redirect;
      rs = reset;
      @(posedge clk);
      #1;
      if (rs) pc = 32'h0;
      else if (r) pc = redir_target;
      else if (!h) pc = pc + 32'd4;
      pc_redirect = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] t);
      pc_redirect  = 1'b1;
      redir_target = t;
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pc_redirect = 1'b0;
      exp_q.delete();
      pend_q.delete();
      step();
      settle();
      check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      check("rst_inst_data", inst_data, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("rst_pc_hold", {31'h0, pc_hold}, 32'h0);
      step();
      reset = 1'b0;
   endtask

   task automatic expect_inst(input string name, input logic [31:0] p);
      check({name, "_valid"}, {31'h0, inst_valid}, 32'h1);
      check({name, "_pc"}, inst_pc, p);
   endtask

   initial begin
      reset = 1'b1; pc = 32'h0; pc_redirect = 1'b0;
      imem_req_ready = 1'b1; inst_ready = 1'b1;

      // Reset then stream
      lat = 1; err_addr = 32'hFFFF_FFFF;
      do_reset();
      settle();
      check("c0_inst_valid", {31'h0, inst_valid}, 32'h0);
      check("c0_req_addr", imem_req_addr, 32'h0);
      step(); settle();
      check("c1_pc_hold", {31'h0, pc_hold}, 32'h0);
      step(); settle(); expect_inst("stream0", 32'h0);
      check("c2_pc_hold", {31'h0, pc_hold}, 32'h0);
      step(); settle(); expect_inst("stream1", 32'h4);
      step(); settle(); expect_inst("stream2", 32'h8);
      check("c4_pc_hold", {31'h0, pc_hold}, 32'h0);
      step();

      // Back-pressure
      inst_ready = 1'b0;
      do_reset();
      step(); step(); settle();
      check("bp_hold", {31'h0, pc_hold}, 32'h1);
      check("bp_req_valid", {31'h0, imem_req_valid}, 32'h0);
      step(); settle();
      check("bp_hold2", {31'h0, pc_hold}, 32'h1);
      check("bp_addr_frozen", imem_req_addr, 32'h8);
      inst_ready = 1'b1; settle();
      expect_inst("bp_head", 32'h0);
      check("bp_release_req", {31'h0, imem_req_valid}, 32'h1);
      check("bp_release_addr", imem_req_addr, 32'h8);
      check("bp_release_hold", {31'h0, pc_hold}, 32'h0);
      for (int i = 0; i < 4; i++) step();

      // Memory stall
      imem_req_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         settle();
         check("stall_hold", {31'h0, pc_hold}, 32'h1);
         check("stall_addr", imem_req_addr, 32'h0);
         check("stall_no_inst", {31'h0, inst_valid}, 32'h0);
         step();
      end
      imem_req_ready = 1'b1; settle();
      check("stall_release_hold", {31'h0, pc_hold}, 32'h0);
      step(); settle();
      check("stall_no_alloc", {31'h0, inst_valid}, 32'h0);
      step(); settle(); expect_inst("stall_first", 32'h0);
      for (int i = 0; i < 3; i++) step();

      // Redirect with two requests in flight
      lat = 3;
      do_reset();
      redirect(32'h10); step(); settle();
      check("rd_addr_10", imem_req_addr, 32'h10);
      step(); step(); settle();
      check("rd_full_req", {31'h0, imem_req_valid}, 32'h0);
      redirect(32'h100); settle();
      check("rd_r_hold", {31'h0, pc_hold}, 32'h0);
      check("rd_r_req", {31'h0, imem_req_valid}, 32'h0);
      check("rd_r_inst", {31'h0, inst_valid}, 32'h0);
      step(); settle();
      check("rd_target_addr", imem_req_addr, 32'h100);
      step(); step(); settle();
      check("rd_refill_hold", {31'h0, pc_hold}, 32'h1);
      check("rd_no_stale", {31'h0, inst_valid}, 32'h0);
      step(); step(); settle();
      expect_inst("rd_first", 32'h100);
      check("rd_first_data", inst_data, 32'hC0DE_0100);
      for (int i = 0; i < 8; i++) step();

      // Redirect while full and stalled
      lat = 1; inst_ready = 1'b0;
      do_reset();
      step(); step(); settle();
      check("rf_full_hold", {31'h0, pc_hold}, 32'h1);
      step();
      inst_ready = 1'b1;
      redirect(32'h200); settle();
      check("rf_r_hold", {31'h0, pc_hold}, 32'h0);
      check("rf_r_inst", {31'h0, inst_valid}, 32'h0);
      step(); settle();
      check("rf_empty", {31'h0, inst_valid}, 32'h0);
      check("rf_req", {31'h0, imem_req_valid}, 32'h1);
      check("rf_req_addr", imem_req_addr, 32'h200);
      step(); step(); settle();
      expect_inst("rf_first", 32'h200);
      for (int i = 0; i < 3; i++) step();

      // Error response
      err_addr = 32'h8;
      do_reset();
      step(); step(); step(); step(); settle();
      expect_inst("err", 32'h8);
      check("err_data", inst_data, 32'h0000_0013);
      check("err_fault", {31'h0, inst_fault}, 32'h1);
      step(); settle();
      expect_inst("clean", 32'hC);
      check("clean_fault", {31'h0, inst_fault}, 32'h0);
      check("clean_data", inst_data, 32'hC0DE_000C);
      for (int i = 0; i < 3; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
